// File: rtl/ours_xm_to_jtag_burst.sv
// AXI-slave to JTAG request bridge: accepts one FIXED/INCR burst at a time and
// splits it into per-beat JTAG read / full-write / masked-write requests.
module ours_xm_to_jtag_burst #(
  parameter int AXI_ID_W    = 12,
  parameter int AXI_ADDR_W  = 64,
  parameter int AXI_BURST_W = 4,
  parameter int AXI_DATA_W  = 64,
  parameter int AXI_WSTRB_W = 8,
  parameter int JTAG_ADDR_W = 40,
  parameter int JTAG_OP_W   = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [AXI_ID_W-1:0]    xm_awid,
  input  logic [AXI_ADDR_W-1:0]  xm_awaddr,
  input  logic [AXI_BURST_W-1:0] xm_awlen,
  input  logic [2:0]             xm_awsize,
  input  logic [1:0]             xm_awburst,
  input  logic                   xm_awvalid,
  output logic                   xm_awready,
  input  logic [AXI_DATA_W-1:0]  xm_wdata,
  input  logic [AXI_WSTRB_W-1:0] xm_wstrb,
  input  logic                   xm_wlast,
  input  logic                   xm_wvalid,
  output logic                   xm_wready,
  output logic [AXI_ID_W-1:0]    xm_bid,
  output logic [1:0]             xm_bresp,
  output logic                   xm_bvalid,
  input  logic                   xm_bready,
  input  logic [AXI_ID_W-1:0]    xm_arid,
  input  logic [AXI_ADDR_W-1:0]  xm_araddr,
  input  logic [AXI_BURST_W-1:0] xm_arlen,
  input  logic [2:0]             xm_arsize,
  input  logic [1:0]             xm_arburst,
  input  logic                   xm_arvalid,
  output logic                   xm_arready,
  output logic [AXI_ID_W-1:0]    xm_rid,
  output logic [AXI_DATA_W-1:0]  xm_rdata,
  output logic [1:0]             xm_rresp,
  output logic                   xm_rlast,
  output logic                   xm_rvalid,
  input  logic                   xm_rready,
  output logic                   jtag_req_vld,
  input  logic                   jtag_req_rdy,
  output logic [JTAG_OP_W-1:0]   jtag_req_op,
  output logic [JTAG_ADDR_W-1:0] jtag_req_addr,
  output logic [AXI_DATA_W-1:0]  jtag_req_data,
  output logic [AXI_WSTRB_W-1:0] jtag_req_strb,
  input  logic                   jtag_rd_resp_vld,
  output logic                   jtag_rd_resp_rdy,
  input  logic [AXI_DATA_W-1:0]  jtag_rd_resp_data
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [JTAG_OP_W-1:0] OP_READ = JTAG_OP_W'(0);
  localparam logic [JTAG_OP_W-1:0] OP_FULL = JTAG_OP_W'(1);
  localparam logic [JTAG_OP_W-1:0] OP_MASK = JTAG_OP_W'(2);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_ISSUE, BRESP} state_t;

  // The AXI encodings are ordered by severity, so the sticky merge is a max.
  function automatic logic [1:0] merge_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t                 state_q, state_d;
  logic                   last_wr_q, last_wr_d;
  logic [AXI_ID_W-1:0]    id_q, id_d;
  logic [AXI_ADDR_W-1:0]  addr_q, addr_d;
  logic [AXI_BURST_W-1:0] len_q, len_d;
  logic [2:0]             size_q, size_d;
  logic [1:0]             burst_q, burst_d;
  logic [AXI_BURST_W-1:0] beat_q, beat_d;
  logic [1:0]             resp_q, resp_d;
  logic [AXI_DATA_W-1:0]  rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;

  logic                  gnt_rd, gnt_wr;
  logic                  beat_oor, burst_bad, beat_skip, last_beat;
  logic                  strb_full, strb_none;
  logic [1:0]            skip_resp, wbeat_resp;
  logic [AXI_ADDR_W-1:0] next_addr;

  assign gnt_rd     = xm_arvalid & (~xm_awvalid | last_wr_q);
  assign gnt_wr     = xm_awvalid & ~gnt_rd;
  assign beat_oor   = |addr_q[AXI_ADDR_W-1:JTAG_ADDR_W];
  assign burst_bad  = burst_q[1];
  assign beat_skip  = beat_oor | burst_bad;
  assign skip_resp  = beat_oor ? RESP_DECERR : RESP_SLVERR;
  assign last_beat  = (beat_q == len_q);
  assign strb_full  = &xm_wstrb;
  assign strb_none  = ~|xm_wstrb;
  assign next_addr  = (burst_q == BURST_INCR) ? addr_q + (AXI_ADDR_W'(1) << size_q) : addr_q;
  assign wbeat_resp = merge_resp(beat_skip ? skip_resp : RESP_OKAY,
                                 (xm_wlast != last_beat) ? RESP_SLVERR : RESP_OKAY);

  assign xm_rdata      = rdata_q;
  assign xm_rresp      = rresp_q;
  assign xm_rid        = id_q;
  assign xm_bid        = id_q;
  assign xm_bresp      = resp_q;
  assign jtag_req_addr = addr_q[JTAG_ADDR_W-1:0];
  assign jtag_req_data = xm_wdata;
  assign jtag_req_strb = xm_wstrb;

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    xm_arready       = 1'b0;
    xm_awready       = 1'b0;
    xm_wready        = 1'b0;
    xm_bvalid        = 1'b0;
    xm_rvalid        = 1'b0;
    xm_rlast         = 1'b0;
    jtag_req_vld     = 1'b0;
    jtag_req_op      = OP_READ;
    jtag_rd_resp_rdy = 1'b0;

    case (state_q)
      IDLE: begin
        xm_arready = gnt_rd;
        xm_awready = gnt_wr;
        if (gnt_rd) begin
          id_d      = xm_arid;
          addr_d    = xm_araddr;
          len_d     = xm_arlen;
          size_d    = xm_arsize;
          burst_d   = xm_arburst;
          beat_d    = '0;
          resp_d    = RESP_OKAY;
          last_wr_d = 1'b0;
          state_d   = RD_ISSUE;
        end else if (gnt_wr) begin
          id_d      = xm_awid;
          addr_d    = xm_awaddr;
          len_d     = xm_awlen;
          size_d    = xm_awsize;
          burst_d   = xm_awburst;
          beat_d    = '0;
          resp_d    = RESP_OKAY;
          last_wr_d = 1'b1;
          state_d   = WR_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (beat_skip) begin
          rdata_d = '0;
          rresp_d = skip_resp;
          state_d = RD_RESP;
        end else begin
          jtag_req_vld = 1'b1;
          if (jtag_req_rdy) state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        jtag_rd_resp_rdy = 1'b1;
        if (jtag_rd_resp_vld) begin
          rdata_d = jtag_rd_resp_data;
          rresp_d = RESP_OKAY;
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        xm_rvalid = 1'b1;
        xm_rlast  = last_beat;
        if (xm_rready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            addr_d  = next_addr;
            state_d = RD_ISSUE;
          end
        end
      end
      WR_ISSUE: begin
        // Beats with nothing to send to JTAG are drained locally.
        if (beat_skip || strb_none) begin
          xm_wready = 1'b1;
        end else begin
          jtag_req_vld = xm_wvalid;
          jtag_req_op  = strb_full ? OP_FULL : OP_MASK;
          xm_wready    = jtag_req_rdy;
        end
        if (xm_wvalid && xm_wready) begin
          resp_d = merge_resp(resp_q, wbeat_resp);
          if (last_beat) begin
            state_d = BRESP;
          end else begin
            beat_d = beat_q + 1'b1;
            addr_d = next_addr;
          end
        end
      end
      BRESP: begin
        xm_bvalid = 1'b1;
        if (xm_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_ours_xm_to_jtag_burst.sv
// Directed bench for ours_xm_to_jtag_burst: single-beat vector table plus
// multi-beat, arbitration, backpressure and reset sequences.
module tb_ours_xm_to_jtag_burst;

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] xm_awid, xm_arid, xm_bid, xm_rid;
  logic [63:0] xm_awaddr, xm_araddr;
  logic [3:0]  xm_awlen, xm_arlen;
  logic [2:0]  xm_awsize, xm_arsize;
  logic [1:0]  xm_awburst, xm_arburst, xm_bresp, xm_rresp;
  logic        xm_awvalid, xm_awready, xm_arvalid, xm_arready;
  logic [63:0] xm_wdata, xm_rdata;
  logic [7:0]  xm_wstrb;
  logic        xm_wlast, xm_wvalid, xm_wready;
  logic        xm_bvalid, xm_bready, xm_rlast, xm_rvalid, xm_rready;
  logic        jtag_req_vld, jtag_req_rdy;
  logic [1:0]  jtag_req_op;
  logic [39:0] jtag_req_addr;
  logic [63:0] jtag_req_data;
  logic [7:0]  jtag_req_strb;
  logic        jtag_rd_resp_vld, jtag_rd_resp_rdy;
  logic [63:0] jtag_rd_resp_data;

  int n_cmp = 0;
  int n_fail = 0;

  ours_xm_to_jtag_burst dut (
    .clk(clk), .rstn(rstn),
    .xm_awid(xm_awid), .xm_awaddr(xm_awaddr), .xm_awlen(xm_awlen), .xm_awsize(xm_awsize),
    .xm_awburst(xm_awburst), .xm_awvalid(xm_awvalid), .xm_awready(xm_awready),
    .xm_wdata(xm_wdata), .xm_wstrb(xm_wstrb), .xm_wlast(xm_wlast),
    .xm_wvalid(xm_wvalid), .xm_wready(xm_wready),
    .xm_bid(xm_bid), .xm_bresp(xm_bresp), .xm_bvalid(xm_bvalid), .xm_bready(xm_bready),
    .xm_arid(xm_arid), .xm_araddr(xm_araddr), .xm_arlen(xm_arlen), .xm_arsize(xm_arsize),
    .xm_arburst(xm_arburst), .xm_arvalid(xm_arvalid), .xm_arready(xm_arready),
    .xm_rid(xm_rid), .xm_rdata(xm_rdata), .xm_rresp(xm_rresp), .xm_rlast(xm_rlast),
    .xm_rvalid(xm_rvalid), .xm_rready(xm_rready),
    .jtag_req_vld(jtag_req_vld), .jtag_req_rdy(jtag_req_rdy), .jtag_req_op(jtag_req_op),
    .jtag_req_addr(jtag_req_addr), .jtag_req_data(jtag_req_data), .jtag_req_strb(jtag_req_strb),
    .jtag_rd_resp_vld(jtag_rd_resp_vld), .jtag_rd_resp_rdy(jtag_rd_resp_rdy),
    .jtag_rd_resp_data(jtag_rd_resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, got %0d compared / %0d mismatched", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [1:0]  burst;
    logic [7:0]  strb;
    bit          wlast;
    logic [63:0] data;
    bit          exp_req;
    logic [1:0]  exp_op;
    logic [1:0]  exp_resp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_ar(input logic [11:0] id, input logic [63:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    xm_arid = id; xm_araddr = addr; xm_arlen = len; xm_arsize = size; xm_arburst = burst;
    xm_arvalid = 1'b1;
    #1;
    while (!xm_arready && t < 50) begin tick(); t++; end
    chk("arready", xm_arready, 1);
    tick();
    xm_arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [11:0] id, input logic [63:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    xm_awid = id; xm_awaddr = addr; xm_awlen = len; xm_awsize = size; xm_awburst = burst;
    xm_awvalid = 1'b1;
    #1;
    while (!xm_awready && t < 50) begin tick(); t++; end
    chk("awready", xm_awready, 1);
    tick();
    xm_awvalid = 1'b0;
  endtask

  // One R beat; hold keeps rready low that many cycles while checking stability.
  task automatic rd_beat(input bit exp_req, input logic [63:0] exp_jaddr, input logic [63:0] jdata,
                         input logic [1:0] exp_resp, input bit exp_last, input logic [11:0] exp_id,
                         input int hold);
    int t = 0;
    bit saw = 0;
    bit bad = 0;
    logic [63:0] exp_rdata;
    exp_rdata = exp_req ? jdata : 64'h0;
    if (exp_req) begin
      while (!jtag_req_vld && t < 50) begin tick(); t++; end
      chk("rd_req_vld", jtag_req_vld, 1);
      chk("rd_req_op", jtag_req_op, 0);
      chk("rd_req_addr", jtag_req_addr, exp_jaddr);
      jtag_req_rdy = 1'b1;
      tick();
      jtag_req_rdy = 1'b0;
      chk("rd_resp_rdy", jtag_rd_resp_rdy, 1);
      jtag_rd_resp_vld = 1'b1;
      jtag_rd_resp_data = jdata;
      tick();
      jtag_rd_resp_vld = 1'b0;
      jtag_rd_resp_data = 64'hDEAD_DEAD_DEAD_DEAD;
      chk("rvalid_latency", xm_rvalid, 1);
    end else begin
      while (!xm_rvalid && t < 50) begin
        if (jtag_req_vld) saw = 1;
        tick();
        t++;
      end
      chk("rvalid_skip", xm_rvalid, 1);
      chk("skip_no_jtag_req", saw, 0);
    end
    chk("rdata", xm_rdata, exp_rdata);
    chk("rresp", xm_rresp, exp_resp);
    chk("rlast", xm_rlast, exp_last);
    chk("rid", xm_rid, exp_id);
    for (int h = 0; h < hold; h++) begin
      tick();
      if (!xm_rvalid || xm_rdata !== exp_rdata || jtag_req_vld) bad = 1;
    end
    if (hold > 0) chk("r_backpressure_stable", bad, 0);
    xm_rready = 1'b1;
    tick();
    xm_rready = 1'b0;
  endtask

  task automatic wr_beat(input logic [63:0] data, input logic [7:0] strb, input bit last,
                         input bit exp_req, input logic [1:0] exp_op, input logic [63:0] exp_jaddr);
    xm_wvalid = 1'b1; xm_wdata = data; xm_wstrb = strb; xm_wlast = last;
    #1;
    if (exp_req) begin
      chk("w_req_vld", jtag_req_vld, 1);
      chk("w_req_op", jtag_req_op, exp_op);
      chk("w_req_addr", jtag_req_addr, exp_jaddr);
      chk("w_req_data", jtag_req_data, data);
      if (exp_op == 2'b10) chk("w_req_strb", jtag_req_strb, strb);
      chk("wready_held_without_jtag", xm_wready, 0);
      jtag_req_rdy = 1'b1;
      #1;
      chk("wready_with_jtag", xm_wready, 1);
    end else begin
      chk("w_no_jtag_req", jtag_req_vld, 0);
      chk("wready_drain", xm_wready, 1);
    end
    tick();
    xm_wvalid = 1'b0; xm_wlast = 1'b0; jtag_req_rdy = 1'b0;
  endtask

  task automatic b_chk(input logic [11:0] exp_id, input logic [1:0] exp_resp);
    int t = 0;
    while (!xm_bvalid && t < 50) begin tick(); t++; end
    chk("bvalid", xm_bvalid, 1);
    chk("bresp", xm_bresp, exp_resp);
    chk("bid", xm_bid, exp_id);
    xm_bready = 1'b1;
    tick();
    xm_bready = 1'b0;
  endtask

  vec_t vecs[11];

  initial begin
    int t;
    int rd_left, wr_left;
    bit got_rd;

    vecs[0]  = '{0, 64'h40,                  2'b01, 8'h00, 1, 64'h1234_5678_9ABC_DEF0, 1, 2'b00, 2'b00};
    vecs[1]  = '{0, 64'h100_0000_0000,       2'b01, 8'h00, 1, 64'h55,                  0, 2'b00, 2'b11};
    vecs[2]  = '{0, 64'h80,                  2'b10, 8'h00, 1, 64'h66,                  0, 2'b00, 2'b10};
    vecs[3]  = '{0, 64'hFF_FFFF_FFF8,        2'b00, 8'h00, 1, 64'hFEDC_BA98_7654_3210, 1, 2'b00, 2'b00};
    vecs[4]  = '{1, 64'h200,                 2'b01, 8'hFF, 1, 64'hAAAA_0000_BBBB_1111, 1, 2'b01, 2'b00};
    vecs[5]  = '{1, 64'h208,                 2'b01, 8'h3C, 1, 64'h0102_0304_0506_0708, 1, 2'b10, 2'b00};
    vecs[6]  = '{1, 64'h210,                 2'b01, 8'h00, 1, 64'h99,                  0, 2'b00, 2'b00};
    vecs[7]  = '{1, 64'h8000_0000_0000_0000, 2'b01, 8'hFF, 1, 64'h77,                  0, 2'b00, 2'b11};
    vecs[8]  = '{1, 64'h300,                 2'b10, 8'hFF, 1, 64'h88,                  0, 2'b00, 2'b10};
    vecs[9]  = '{1, 64'h300,                 2'b11, 8'hFF, 1, 64'h89,                  0, 2'b00, 2'b10};
    vecs[10] = '{1, 64'h310,                 2'b01, 8'hFF, 0, 64'h4242,                1, 2'b01, 2'b10};

    rstn = 1'b0;
    xm_awid = '0; xm_awaddr = '0; xm_awlen = '0; xm_awsize = '0; xm_awburst = '0; xm_awvalid = 1'b0;
    xm_arid = '0; xm_araddr = '0; xm_arlen = '0; xm_arsize = '0; xm_arburst = '0; xm_arvalid = 1'b0;
    xm_wdata = '0; xm_wstrb = '0; xm_wlast = 1'b0; xm_wvalid = 1'b0;
    xm_bready = 1'b0; xm_rready = 1'b0;
    jtag_req_rdy = 1'b0; jtag_rd_resp_vld = 1'b0; jtag_rd_resp_data = '0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    chk("rst_arready", xm_arready, 0);
    chk("rst_awready", xm_awready, 0);
    chk("rst_wready", xm_wready, 0);
    chk("rst_bvalid", xm_bvalid, 0);
    chk("rst_rvalid", xm_rvalid, 0);
    chk("rst_jtag_req_vld", jtag_req_vld, 0);
    chk("rst_jtag_rd_resp_rdy", jtag_rd_resp_rdy, 0);
    chk("rst_bresp", xm_bresp, 0);
    chk("rst_rresp", xm_rresp, 0);
    chk("rst_rid", xm_rid, 0);
    chk("rst_bid", xm_bid, 0);
    chk("rst_rdata", xm_rdata, 0);

    // Single-beat vector table.
    for (int i = 0; i < 11; i++) begin
      if (!vecs[i].wr) begin
        send_ar(12'(i + 16), vecs[i].addr, 4'd0, 3'd3, vecs[i].burst);
        rd_beat(vecs[i].exp_req, vecs[i].addr, vecs[i].data, vecs[i].exp_resp, 1, 12'(i + 16), 0);
      end else begin
        send_aw(12'(i + 16), vecs[i].addr, 4'd0, 3'd3, vecs[i].burst);
        wr_beat(vecs[i].data, vecs[i].strb, vecs[i].wlast, vecs[i].exp_req, vecs[i].exp_op, vecs[i].addr);
        b_chk(12'(i + 16), vecs[i].exp_resp);
      end
    end

    // INCR read burst of 4 beats, size 8 bytes.
    send_ar(12'h5A5, 64'h100, 4'd3, 3'd3, 2'b01);
    for (int k = 0; k < 4; k++)
      rd_beat(1, 64'h100 + 64'(8 * k), 64'hA000 + 64'(k), 2'b00, k == 3, 12'h5A5, 0);

    // FIXED write burst: full then masked write to the same address.
    send_aw(12'h3C3, 64'h400, 4'd1, 3'd3, 2'b00);
    wr_beat(64'h1111_1111_1111_1111, 8'hFF, 0, 1, 2'b01, 64'h400);
    chk("b_before_last_accept", xm_bvalid, 0);
    wr_beat(64'h2222_2222_2222_2222, 8'h0F, 1, 1, 2'b10, 64'h400);
    b_chk(12'h3C3, 2'b00);

    // Contention: last grant was a write, so order must be R, W, R, W.
    rd_left = 2; wr_left = 2;
    xm_arid = 12'h0A1; xm_araddr = 64'h800; xm_arlen = 4'd0; xm_arsize = 3'd3; xm_arburst = 2'b01;
    xm_awid = 12'h0B2; xm_awaddr = 64'h900; xm_awlen = 4'd0; xm_awsize = 3'd3; xm_awburst = 2'b01;
    xm_arvalid = 1'b1; xm_awvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      #1;
      while (!(xm_arready || xm_awready) && t < 50) begin tick(); t++; end
      got_rd = xm_arready;
      chk("grant_order", got_rd, (k % 2) == 0);
      chk("grant_onehot", xm_arready & xm_awready, 0);
      tick();
      if (got_rd) begin
        rd_left--;
        if (rd_left == 0) xm_arvalid = 1'b0;
        rd_beat(1, 64'h800, 64'hC0 + 64'(k), 2'b00, 1, 12'h0A1, 0);
      end else begin
        wr_left--;
        if (wr_left == 0) xm_awvalid = 1'b0;
        wr_beat(64'hD0 + 64'(k), 8'hFF, 1, 1, 2'b01, 64'h900);
        b_chk(12'h0B2, 2'b00);
      end
    end
    xm_arvalid = 1'b0; xm_awvalid = 1'b0;

    // R backpressure on the first of two beats.
    send_ar(12'h021, 64'h500, 4'd1, 3'd3, 2'b01);
    rd_beat(1, 64'h500, 64'hBEEF, 2'b00, 0, 12'h021, 10);
    rd_beat(1, 64'h508, 64'hCAFE, 2'b00, 1, 12'h021, 0);

    // Early wlast on beat 0 of a 2-beat write.
    send_aw(12'h031, 64'hA00, 4'd1, 3'd3, 2'b01);
    wr_beat(64'h10, 8'hFF, 1, 1, 2'b01, 64'hA00);
    wr_beat(64'h20, 8'hFF, 1, 1, 2'b01, 64'hA08);
    b_chk(12'h031, 2'b10);

    // Asynchronous reset while waiting on JTAG read data.
    send_ar(12'h077, 64'h600, 4'd0, 3'd3, 2'b01);
    t = 0;
    while (!jtag_req_vld && t < 50) begin tick(); t++; end
    jtag_req_rdy = 1'b1;
    tick();
    jtag_req_rdy = 1'b0;
    chk("pre_reset_rd_wait", jtag_rd_resp_rdy, 1);
    rstn = 1'b0;
    tick();
    chk("arst_rvalid", xm_rvalid, 0);
    chk("arst_jtag_req_vld", jtag_req_vld, 0);
    chk("arst_jtag_rd_resp_rdy", jtag_rd_resp_rdy, 0);
    chk("arst_bvalid", xm_bvalid, 0);
    chk("arst_rid", xm_rid, 0);
    rstn = 1'b1;
    tick();
    send_ar(12'h078, 64'h700, 4'd0, 3'd3, 2'b01);
    rd_beat(1, 64'h700, 64'h7777_0000_7777_0000, 2'b00, 1, 12'h078, 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ours_xm_to_jtag_burst.md
Name: ours_xm_to_jtag_burst

Overview:
Next-generation AXI-slave-to-JTAG request bridge. Unlike the current single-beat bridge, it accepts AXI bursts (FIXED/INCR, any AXI_BURST_W length) and splits each into per-beat JTAG requests. It supports byte-masked writes and range-checks each beat address, returning DECERR for out-of-range beats. It sits between the debug AXI fabric and the existing JTAG request processor (jtag_req_*/jtag_rd_resp_* interface), handling one burst at a time.

Parameters:
AXI_ID_W, 12, AXI ID width
AXI_ADDR_W, 64, AXI address width
AXI_BURST_W, 4, axlen width; burst = axlen+1 beats
AXI_DATA_W, 64, data width
AXI_WSTRB_W, 8, AXI_DATA_W/8
JTAG_ADDR_W, 40, JTAG address width; beat addr bits [AXI_ADDR_W-1:JTAG_ADDR_W] must be 0
JTAG_OP_W, 2, JTAG op width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
xm_awid/awaddr/awlen/awsize/awburst  in  AXI_ID_W/AXI_ADDR_W/AXI_BURST_W/3/2  AW payload
xm_awvalid in 1; xm_awready out 1  AW handshake
xm_wdata/wstrb/wlast  in  AXI_DATA_W/AXI_WSTRB_W/1  W payload
xm_wvalid in 1; xm_wready out 1  W handshake
xm_bid/bresp  out  AXI_ID_W/2  B payload
xm_bvalid out 1; xm_bready in 1  B handshake
xm_arid/araddr/arlen/arsize/arburst  in  as AW  AR payload
xm_arvalid in 1; xm_arready out 1  AR handshake
xm_rid/rdata/rresp/rlast  out  AXI_ID_W/AXI_DATA_W/2/1  R payload
xm_rvalid out 1; xm_rready in 1  R handshake
jtag_req_vld out 1; jtag_req_rdy in 1  request handshake
jtag_req_op  out  JTAG_OP_W  00 read, 01 full write, 10 masked write
jtag_req_addr  out  JTAG_ADDR_W  beat address
jtag_req_data  out  AXI_DATA_W  write data
jtag_req_strb  out  AXI_WSTRB_W  byte mask (valid for op 10)
jtag_rd_resp_vld in 1; jtag_rd_resp_rdy out 1  read data handshake
jtag_rd_resp_data  in  AXI_DATA_W  read data

Behaviour:
- Reset: state IDLE; all valid/ready outputs 0; bresp/rresp/rid/bid/rdata 0; arbiter last-grant = write (first contention goes to read).
- States: IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_ISSUE, BRESP.
- IDLE: if only one of arvalid/awvalid is high, grant it; if both, grant the one not granted last. The granted ready is asserted combinationally in the same cycle. On handshake, latch id, addr, len, size, burst; clear beat counter and sticky resp.
- Burst type: FIXED keeps addr; INCR adds (1<<size) per beat, modulo 2^AXI_ADDR_W. WRAP/reserved: no JTAG traffic; every beat is answered/consumed with SLVERR.
- Beat out of range (upper addr bits nonzero): no JTAG request for that beat; resp DECERR.
- RD_ISSUE: jtag_req_vld=1, op 00. On rdy go to RD_WAIT. Skipped beat goes directly to RD_RESP with rdata 0.
- RD_WAIT: jtag_rd_resp_rdy=1. On vld, register data into R and go to RD_RESP. rvalid rises exactly 1 cycle after jtag_rd_resp_vld.
- RD_RESP: rvalid held with stable payload until rready. rlast=1 on beat len. After the last beat go to IDLE, else advance addr and go to RD_ISSUE.
- WR_ISSUE: per beat, jtag_req_vld=wvalid, xm_wready=jtag_req_rdy.
  - wstrb all ones: op 01.
  - wstrb partial: op 10 with jtag_req_strb=wstrb.
  - wstrb zero, or skipped/error beat: no JTAG request; wready=1.
  - A W beat is never accepted without its JTAG request, except in the no-request cases above.
- Beat count is set by awlen only. wlast mismatch (early, or missing on the final beat) sets sticky SLVERR.
- Sticky resp priority: DECERR > SLVERR > OKAY. After the last beat go to BRESP.
- BRESP: bvalid=1 with bid and sticky resp, held until bready, then IDLE. B is issued only after every JTAG write of the burst has been accepted.
- xm_wready=0 outside WR_ISSUE. jtag_rd_resp_rdy=0 outside RD_WAIT. A stray jtag_rd_resp_vld elsewhere is ignored.
- Only one burst is in flight; AR/AW stay unready outside IDLE.
- Async reset mid-burst returns to IDLE immediately; partial burst state is discarded.

Test Plan:
- INCR read, araddr 0x100, arlen 3, arsize 3 -> JTAG reads at 0x100/0x108/0x110/0x118; 4 R beats, rlast only on 4th, rresp 0, rid echoed.
- FIXED write, awlen 1, wstrb 0xFF then 0x0F -> ops 01 then 10 at the same addr, strb 0x0F; a single B with OKAY after the 2nd JTAG accept.
- Simultaneous arvalid/awvalid held for two bursts each -> grant order read, write, read, write.
- araddr 0x1_0000_0000_00 (bit 40 set), arlen 0 -> no jtag_req_vld; R beat rdata 0, rresp DECERR.
- R backpressure: rready low 10 cycles on beat 1 of 2 -> rdata stable, no 2nd JTAG request until accept. Also wlast asserted on beat 0 of awlen 1 -> bresp SLVERR.
- Assert rstn low while in RD_WAIT -> all valids 0 next edge; a new AR is then accepted normally.
